// File: rtl/platform_pio_buttons_if.sv
// platform_pio_buttons_if: Avalon-MM slave port of the button PIO plus its interrupt line.
interface platform_pio_buttons_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    modport master (output address, chipselect, write_n, writedata, input readdata, irq);
    modport slave  (input address, chipselect, write_n, writedata, output readdata, irq);
endinterface

// File: rtl/platform_pio_buttons.sv
// platform_pio_buttons: debounced input PIO with sticky edge capture and masked level irq.
module platform_pio_buttons #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_TYPE       = 1,
    parameter int IDLE_LEVEL      = 1
) (
    input logic                   clk,
    input logic                   reset_n,
    input logic [WIDTH-1:0]       in_port,
    platform_pio_buttons_if.slave bus
);
    localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WIDTH-1:0] IDLE = {WIDTH{IDLE_LEVEL != 0}};
    logic [WIDTH-1:0] s1, s2, stable, accept, set, clr, irq_mask, edge_cap, rd_sel;
    logic [CW-1:0]    cnt [WIDTH];
    logic             wr;
    logic             unused_wd;
    assign wr        = bus.chipselect && !bus.write_n;
    assign unused_wd = ^bus.writedata;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= IDLE;
            s2 <= IDLE;
        end else begin
            s1 <= in_port;
            s2 <= s1;
        end
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_deb
        assign accept[i] = (s2[i] != stable[i]) && (cnt[i] == CNT_MAX);
        // any sample matching the accepted level restarts the count, so bounces never accumulate
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt[i]    <= '0;
                stable[i] <= IDLE[i];
            end else if (s2[i] == stable[i] || accept[i]) begin
                cnt[i]    <= '0;
                stable[i] <= s2[i];
            end else begin
                cnt[i]    <= cnt[i] + 1'b1;
            end
        end
    end
    assign set = EDGE_TYPE == 0 ? (accept & s2) :
                 EDGE_TYPE == 1 ? (accept & ~s2) : accept;
    assign clr = (wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
    // a qualifying edge wins over a same-cycle software clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
            edge_cap <= '0;
        end else begin
            if (wr && bus.address == 2'd2) irq_mask <= bus.writedata[WIDTH-1:0];
            edge_cap <= (edge_cap & ~clr) | set;
        end
    end
    assign rd_sel = bus.address == 2'd0 ? stable :
                    bus.address == 2'd2 ? irq_mask :
                    bus.address == 2'd3 ? edge_cap : '0;
    assign bus.readdata = 32'(rd_sel);
    assign bus.irq      = |(edge_cap & irq_mask);
endmodule

// File: doc/platform_pio_buttons.md
# platform_pio_buttons

- Avalon-MM slave input PIO: the read-side counterpart of the LED output PIO.
- Samples WIDTH external button/switch pins through a two-flop synchronizer and a per-bit debouncer.
- Latches qualifying debounced edges into a sticky edge-capture register and raises a level interrupt to the Nios II processor through a per-bit mask.
- Sits on the same system interconnect as the other PIOs at a 4-word register window.

## Interface

- WIDTH, 4: number of input pins (1..32).
- DEBOUNCE_CYCLES, 50000: consecutive stable clocks required before a pin change is accepted (1 ms at 50 MHz); minimum 1.
- EDGE_TYPE, 1: 0 = rising, 1 = falling, 2 = any edge sets edge-capture.
- IDLE_LEVEL, 1: reset value of synchronizer and debounced bits (buttons are active-low).

Ports:

- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- address  input  2  word address within the register window.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- in_port  input  WIDTH  raw, asynchronous pin inputs.
- readdata  output  32  read data, combinational from address (read latency 0); bits above WIDTH read 0.
- irq  output  1  level interrupt, active high.

## Operation

Register map (write = chipselect && !write_n):

- Address 0, DATA, RO: debounced pin state. Writes are ignored.
- Address 2, IRQMASK, RW: bit i = 1 enables the interrupt for pin i. Reset value 0.
- Address 1, reserved: reads 0, writes ignored.
- Address 3, EDGECAPTURE, R/W1C: writing a 1 to bit i clears it; writing 0 leaves it unchanged. Reset value 0.

Datapath per bit i:

- Synchronizer: `s1 <= in_port[i]`, `s2 <= s1`.
- Debouncer:
  - Counter cnt_i, width clog2(DEBOUNCE_CYCLES) (minimum 1).
  - If s2 == stable_i: cnt_i <= 0.
  - Else if cnt_i == DEBOUNCE_CYCLES-1: stable_i <= s2 and cnt_i <= 0.
  - Else: cnt_i <= cnt_i + 1.
  - A bounce (s2 returns to stable_i) restarts the count.
- Edge-capture set condition, evaluated at the edge where stable_i updates:
  - EDGE_TYPE 0: 0→1.
  - EDGE_TYPE 1: 1→0.
  - EDGE_TYPE 2: either direction.
- Set has priority over a simultaneous W1C clear of the same bit. The bit stays set until cleared by software.
- `irq = |(EDGECAPTURE & IRQMASK)`. irq is combinational from registers and has no internal pulse stretching.

Reset values:

- s1, s2, stable: all IDLE_LEVEL.
- cnt: 0.
- IRQMASK, EDGECAPTURE: 0.
- irq: 0.
- readdata: DATA value, i.e. IDLE_LEVEL bits when address = 0.

## Timing

- Pin change sampled first at edge E0:
  - s2 holds the new value after E0+1.
  - stable_i and EDGECAPTURE update at E0+1+DEBOUNCE_CYCLES.
  - irq rises in the same cycle if the bit is masked in.
- With DEBOUNCE_CYCLES = 1, stable updates at E0+2.
- Register writes take effect at the clock edge on which the write is presented.
- Readdata reflects the register value in the same cycle as the address.
- A W1C write to EDGECAPTURE drops irq in the cycle after the write edge, unless a new edge sets the bit at that same edge.
- A mask write changes irq in the cycle after the write edge.
- Reset asserted mid-count returns all state to reset values immediately, with no edge-capture event. After release, a pin held at non-idle level is debounced normally and sets EDGECAPTURE if it matches EDGE_TYPE.
- Bits are independent; simultaneous edges on several pins set their bits at their own qualifying edges.

## Test plan

- **Reset values.** Pulse reset_n low with in_port = 4'hF. Read addresses 0, 1, 2, 3 → 0xF, 0, 0, 0; irq = 0.
- **Debounce latency.** DEBOUNCE_CYCLES = 8, EDGE_TYPE = 1.
  - Drive in_port[0] to 0 and hold.
  - DATA reads 0xE exactly at edge E0+9; EDGECAPTURE = 0x1 at the same edge.
  - With IRQMASK = 0x1, irq rises then.
- **Bounce rejection.**
  - Toggle in_port[1] low for 5 cycles, high for 2, low for 5 (DEBOUNCE_CYCLES = 8) → DATA stays 0xF and EDGECAPTURE = 0.
  - Then hold low for 8 cycles → bit 1 sets.
- **Mask and W1C.**
  - With EDGECAPTURE = 0x5 and IRQMASK = 0x4: irq = 1.
  - Write 0x4 to address 3 → EDGECAPTURE = 0x1, irq = 0.
  - Write 0x1 to address 2 → irq = 1.
  - Write 0 to address 3 → no change.
- **Set/clear collision.** Issue a W1C of bit 2 on the same edge where bit 2 qualifies a new edge → EDGECAPTURE bit 2 remains 1 and irq stays asserted.
- **EDGE_TYPE = 2 and reset mid-count.**
  - Press and release bit 3 → set on both transitions; clear between them.
  - Assert reset at count 4 → no capture; after release, debounce restarts from 0.
